// File: rtl/time_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : time_display_driver
// Brief    : Converts two fields of the packed countdown time word to BCD with a
//            shift-add-3 FSM and scans them onto a 4-digit common-anode display.
// Revision : 1.0 - initial release
// ============================================================================
module time_display_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [26:0] time_in,
    input  logic        mode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SHIFT  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t             state_q;
    logic               first_q;
    logic [26:0]        last_time_q;
    logic               last_mode_q;
    logic [13:0]        shl_q;
    logic [13:0]        shr_q;
    logic [2:0]         iter_q;
    logic [3:0][3:0]    digits_q;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [6:0]         seg_d;
    logic [3:0]         an_d;
    logic               dp_d;

    logic [5:0]         left_field;
    logic [5:0]         right_field;

    // One double-dabble step: BCD tens in [13:10], units in [9:6], binary below.
    function automatic logic [13:0] dabble(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[9:6] > 4'd4)
            t[9:6] = t[9:6] + 4'd3;
        if (t[13:10] > 4'd4)
            t[13:10] = t[13:10] + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        left_field  = mode ? {1'b0, time_in[26:22]} : time_in[21:16];
        right_field = mode ? time_in[21:16]         : time_in[15:10];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b1;
            last_time_q <= '0;
            last_mode_q <= 1'b0;
            shl_q       <= '0;
            shr_q       <= '0;
            iter_q      <= '0;
            digits_q    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (first_q || (time_in != last_time_q) || (mode != last_mode_q)) begin
                        state_q <= S_LOAD;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    first_q     <= 1'b0;
                    last_time_q <= time_in;
                    last_mode_q <= mode;
                    shl_q       <= {8'b0, left_field};
                    shr_q       <= {8'b0, right_field};
                    iter_q      <= '0;
                    state_q     <= S_SHIFT;
                end
                S_SHIFT: begin
                    shl_q  <= dabble(shl_q);
                    shr_q  <= dabble(shr_q);
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd5)
                        state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    digits_q <= {shl_q[13:10], shl_q[9:6], shr_q[13:10], shr_q[9:6]};
                    busy     <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        idx_d       = idx_q;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
        // Blink only while the last converted time word is zero.
        if (last_time_q == '0) begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            phase_d     = phase_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end
        end
        if (phase_q) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(digits_q[idx_q]);
            dp_d  = (idx_q != 2'd2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg         <= 7'b1111111;
            an          <= 4'b1111;
            dp          <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg         <= seg_d;
            an          <= an_d;
            dp          <= dp_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_display_driver
// Brief    : Directed and randomized checks of time_display_driver against an
//            arithmetic model of the digit selection, conversion and display.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_display_driver;

    localparam int SCAN_DIV  = 2;
    localparam int BLINK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [26:0] time_in;
    logic        mode;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    time_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .time_in (time_in),
        .mode    (mode),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] pack(input int h, input int m, input int s, input int ms);
        return {5'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    // Expected {d3,d2,d1,d0} from plain decimal arithmetic on the selected fields.
    function automatic logic [15:0] expect_digits(input logic [26:0] t, input logic md);
        int l, r;
        l = md ? int'(t[26:22]) : int'(t[21:16]);
        r = md ? int'(t[21:16]) : int'(t[15:10]);
        return {4'(l / 10), 4'(l % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic measure_busy(input string tag, input int exp_len);
        int w;
        int len;
        w = 0;
        while (!busy && w < 12) begin
            step();
            w++;
        end
        if (!busy) begin
            check({tag, "_start"}, 0, 1);
            return;
        end
        len = 0;
        while (busy && len < 40) begin
            len++;
            step();
        end
        check({tag, "_len"}, len, exp_len);
    endtask

    task automatic check_display(input string tag, input logic [15:0] exp);
        logic [3:0] seen;
        int idx;
        seen = '0;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            step();
            check({tag, "_an_onehot"}, 32'($onehot(~an)), 1);
            idx = -1;
            for (int k = 0; k < 4; k++)
                if (an === ~(4'b0001 << k)) idx = k;
            if (idx >= 0) begin
                seen[idx] = 1'b1;
                check({tag, "_seg"}, seg, seg_pat[exp[idx*4 +: 4]]);
                check({tag, "_dp"}, dp, (idx != 2));
            end
        end
        check({tag, "_all_digits"}, seen, 4'hF);
    endtask

    initial begin
        logic [26:0] t1, t1b, t;
        logic        b [48];
        int          rise, npulse, gap, w, nruns, run, blanks;
        int          lens [4];
        logic        blank [40];
        bit          started;

        t1  = pack(1, 23, 45, 500);
        t1b = pack(1, 23, 44, 500);
        time_in = t1;
        mode    = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_busy", busy, 0);

        reset_n = 1'b1;
        step();
        check("first_an", an, 4'b1110);
        check("first_busy", busy, 1);
        measure_busy("first_conv", 8);
        check_display("mmss", expect_digits(t1, 1'b0));

        // Asynchronous reset while digit 2 is lit
        w = 0;
        while (an !== 4'b1011 && w < 20) begin
            step();
            w++;
        end
        check("reach_idx2", an, 4'b1011);
        #2 reset_n = 1'b0;
        #1;
        check("async_an", an, 4'b1111);
        check("async_seg", seg, 7'h7F);
        check("async_dp", dp, 1);
        check("async_busy", busy, 0);
        step();
        reset_n = 1'b1;
        step();
        check("rerel_an", an, 4'b1110);
        check("rerel_busy", busy, 1);
        measure_busy("rerel_conv", 8);
        check_display("rerel", expect_digits(t1, 1'b0));

        // Mode toggle forces reconversion
        mode = 1'b1;
        measure_busy("mode1", 8);
        check_display("hhmm", expect_digits(t1, 1'b1));

        // Change during the second SHIFT cycle: two back-to-back conversions
        mode = 1'b0;
        rise = -1;
        for (int i = 0; i < 48; i++) begin
            step();
            b[i] = busy;
            if (rise < 0 && busy) rise = i;
            if (rise >= 0 && i == rise + 2) time_in = t1b;
        end
        npulse = 0;
        gap = 0;
        for (int k = 0; k < 4; k++) lens[k] = 0;
        for (int i = 0; i < 48; i++) begin
            if (b[i] && (i == 0 || !b[i-1])) npulse++;
            if (b[i] && npulse >= 1 && npulse <= 4) lens[npulse-1]++;
            if (!b[i] && npulse == 1) gap++;
        end
        check("pend_pulses", npulse, 2);
        check("pend_len1", lens[0], 8);
        check("pend_len2", lens[1], 8);
        check("pend_gap", gap, 1);
        check_display("pend", expect_digits(t1b, 1'b0));

        // Unclamped out-of-range fields
        time_in = pack(0, 63, 60, 1);
        measure_busy("unclamp", 8);
        check_display("unclamp", 16'h6360);

        // Randomized fields and modes
        for (int n = 0; n < 16; n++) begin
            t = pack($urandom_range(0, 31), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(2, 999));
            if (t == time_in) t[0] = ~t[0];
            time_in = t;
            mode    = 1'($urandom_range(0, 1));
            measure_busy("rand", 8);
            check_display("rand", expect_digits(t, mode));
        end

        // Expired: blink in 4-clock halves showing 00.00
        time_in = '0;
        mode    = 1'b0;
        measure_busy("zero_conv", 8);
        for (int i = 0; i < 40; i++) begin
            step();
            blank[i] = (an === 4'b1111);
            if (blank[i]) begin
                check("blank_seg", seg, 7'h7F);
                check("blank_dp", dp, 1);
            end else begin
                check("zero_an_onehot", 32'($onehot(~an)), 1);
                check("zero_seg", seg, seg_pat[0]);
            end
        end
        nruns = 0;
        run = 1;
        started = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (blank[i] == blank[i-1]) begin
                run++;
            end else begin
                if (started) begin
                    check("blink_run", run, 4);
                    nruns++;
                end
                started = 1'b1;
                run = 1;
            end
        end
        check("blink_run_count", (nruns >= 5), 1);

        // Nonzero time stops blinking within 9 clocks
        time_in = pack(0, 0, 1, 0);
        repeat (9) step();
        blanks = 0;
        for (int i = 0; i < 16; i++) begin
            if (an === 4'b1111) blanks++;
            step();
        end
        check("blink_stopped", blanks, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
